// File: rtl/wbu_pkg.sv
// wbu_pkg: shared encodings for the writeback / load-store stage.
//   op codes, funct3 width codes, writeback-source select, error causes,
//   FSM state enum, and small width/alignment helper functions.
package wbu_pkg;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   localparam logic [2:0] F3_XX = 3'b111;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_PC4  = 2'b01;
   localparam logic [1:0] WB_CSR  = 2'b10;
   localparam logic [1:0] WB_LOAD = 2'b11;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      WB   = 2'b11
   } wbu_state_e;

   // Non-memory ops always report legal; only loads/stores have width rules.
   function automatic logic width_legal(input logic [1:0] op, input logic [2:0] f3,
                                        input logic is64);
      logic ok;
      ok = 1'b1;
      if (op == OP_LOAD)
         ok = (f3 != F3_XX) && (is64 || ((f3 != F3_D) && (f3 != F3_WU)));
      else if (op == OP_STORE)
         ok = !f3[2] && (is64 || (f3 != F3_D));
      return ok;
   endfunction

   // ofs is the byte offset within the bus word, zero-padded to 3 bits.
   function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] ofs);
      logic mis;
      case (f3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = ofs[0];
         2'b10:   mis = |ofs[1:0];
         default: mis = |ofs;
      endcase
      return mis;
   endfunction

   // Unshifted byte-enable pattern for the access width.
   function automatic logic [7:0] lane_mask(input logic [2:0] f3);
      logic [7:0] m;
      case (f3[1:0])
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wbu_lsu_load_align.sv
// load_align: extracts the addressed bytes from an aligned read word.
//   rdata  in  XLEN   aligned memory read word
//   ofs    in  OFS_W  byte offset of the access within the word
//   funct3 in  3      width / sign code (bit 2 set = zero-extend)
//   data   out XLEN   shifted, truncated and sign/zero-extended value
module load_align
   import wbu_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFS_W = $clog2(NB)
) (
   input  logic [XLEN-1:0]  rdata,
   input  logic [OFS_W-1:0] ofs,
   input  logic [2:0]       funct3,
   output logic [XLEN-1:0]  data
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdata >> {ofs, 3'b000};
      data    = shifted;
      case (funct3[1:0])
         2'b00:   data = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
         2'b01:   data = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
         2'b10:   data = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/wbu_lsu.sv
// wbu_lsu: writeback / load-store stage. Accepts one instruction at a time
// from EXU, performs an optional memory access over a req/gnt + rvalid port
// with a response timeout, then commits to the register file for one cycle.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        EXU handshake (ready only while idle)
//   in_op/funct3/wb_sel/rd   instruction control fields
//   in_addr/wdata/alu_res/pc/csr_out   instruction data fields
//   mem_req/gnt/we/addr/wdata/wmask    memory request channel
//   mem_rvalid/rdata         memory response (also the store ack)
//   rf_wen/waddr/wdata       register-file write port
//   wb_valid/wb_pc           commit pulse and committing PC
//   err/err_cause            exception reported with the commit
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready high
// REQ   | mem_req held with stable address/data until mem_gnt
// WAIT  | request granted, waiting for mem_rvalid
// WB    | one-cycle commit: wb_valid, optional rf write, error report
module wbu_lsu
   import wbu_pkg::*;
#(
   parameter  int XLEN    = 32,
   parameter  int TIMEOUT = 255,
   localparam int NB      = XLEN / 8,
   localparam int OFS_W   = $clog2(NB)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_wb_sel,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [XLEN-1:0] in_alu_res,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_csr_out,
   output logic            mem_req,
   input  logic            mem_gnt,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [NB-1:0]   mem_wmask,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_pc,
   output logic            err,
   output logic [1:0]      err_cause
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

   wbu_state_e state_q, state_d;

   logic [1:0]      op_q;
   logic [2:0]      f3_q;
   logic [1:0]      wb_sel_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] addr_q, wdata_q, alu_q, pc_q, csr_q, rdata_q;
   logic [1:0]      cause_q;
   logic [CNT_W-1:0] cnt_q;

   logic [OFS_W-1:0] ofs, in_ofs;
   logic             in_is_mem, tmo_hit;
   logic [1:0]       in_cause;
   logic [XLEN-1:0]  load_data;

   assign ofs       = addr_q[OFS_W-1:0];
   assign in_ofs    = in_addr[OFS_W-1:0];
   assign in_is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);

   // Illegal width takes priority: without a known width, alignment is moot.
   always_comb begin
      in_cause = CAUSE_NONE;
      if (in_is_mem) begin
         if (!width_legal(in_op, in_funct3, XLEN == 64))
            in_cause = CAUSE_ILLEGAL;
         else if (misaligned(in_funct3, 3'(in_ofs)))
            in_cause = CAUSE_MISALIGN;
      end
   end

   // Abort takes priority over gnt/rvalid in the cycle the counter hits
   // TIMEOUT; mem_req is already low then, so no grant can be lost.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      mem_req  = 1'b0;
      wb_valid = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_is_mem && (in_cause == CAUSE_NONE))
                  state_d = REQ;
               else
                  state_d = WB;
            end
         end
         REQ: begin
            if (cnt_q == TMO_CNT) begin
               tmo_hit = 1'b1;
               state_d = WB;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt)
                  state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == TMO_CNT) begin
               tmo_hit = 1'b1;
               state_d = WB;
            end else if (mem_rvalid) begin
               state_d = WB;
            end
         end
         WB: begin
            wb_valid = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         f3_q     <= '0;
         wb_sel_q <= '0;
         rd_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         alu_q    <= '0;
         pc_q     <= '0;
         csr_q    <= '0;
         rdata_q  <= '0;
         cause_q  <= CAUSE_NONE;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q     <= in_op;
                  f3_q     <= in_funct3;
                  wb_sel_q <= in_wb_sel;
                  rd_q     <= in_rd;
                  addr_q   <= in_addr;
                  wdata_q  <= in_wdata;
                  alu_q    <= in_alu_res;
                  pc_q     <= in_pc;
                  csr_q    <= in_csr_out;
                  // cleared so a non-load selecting load data writes zero
                  rdata_q  <= '0;
                  cause_q  <= in_cause;
                  cnt_q    <= '0;
               end
            end
            REQ, WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (tmo_hit)
                  cause_q <= CAUSE_TIMEOUT;
               else if ((state_q == WAIT) && mem_rvalid)
                  rdata_q <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata  (rdata_q),
      .ofs    (ofs),
      .funct3 (f3_q),
      .data   (load_data)
   );

   assign mem_we    = (op_q == OP_STORE);
   assign mem_addr  = {addr_q[XLEN-1:OFS_W], {OFS_W{1'b0}}};
   assign mem_wdata = wdata_q << {ofs, 3'b000};
   assign mem_wmask = NB'(lane_mask(f3_q) << ofs);

   always_comb begin
      rf_wdata = alu_q;
      case (wb_sel_q)
         WB_PC4:  rf_wdata = pc_q + XLEN'(4);
         WB_CSR:  rf_wdata = csr_q;
         WB_LOAD: rf_wdata = load_data;
         default: rf_wdata = alu_q;
      endcase
   end

   assign rf_wen    = wb_valid && (op_q != OP_STORE) && (cause_q == CAUSE_NONE) && (rd_q != 5'd0);
   assign rf_waddr  = rd_q;
   assign wb_pc     = pc_q;
   assign err       = wb_valid && (cause_q != CAUSE_NONE);
   assign err_cause = wb_valid ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_wbu_lsu.sv
// tb_wbu_lsu: two instances (XLEN=32/TIMEOUT=4 and XLEN=64/TIMEOUT=8) share
// one stimulus bus; sel picks the active instance, the other is held idle.
// Each transaction is predicted by a behavioural model from the access rules
// and compared against what the selected instance commits.
module tb_wbu_lsu;

   localparam int T32 = 4;
   localparam int T64 = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        sel;
   logic        in_valid, mem_gnt, mem_rvalid;
   logic [1:0]  in_op, in_wb_sel;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [63:0] in_addr, in_wdata, in_alu_res, in_pc, in_csr_out, mem_rdata;

   logic        a_in_ready, a_mem_req, a_mem_we, a_rf_wen, a_wb_valid, a_err;
   logic [31:0] a_mem_addr, a_mem_wdata, a_rf_wdata, a_wb_pc;
   logic [3:0]  a_mem_wmask;
   logic [4:0]  a_rf_waddr;
   logic [1:0]  a_err_cause;

   logic        b_in_ready, b_mem_req, b_mem_we, b_rf_wen, b_wb_valid, b_err;
   logic [63:0] b_mem_addr, b_mem_wdata, b_rf_wdata, b_wb_pc;
   logic [7:0]  b_mem_wmask;
   logic [4:0]  b_rf_waddr;
   logic [1:0]  b_err_cause;

   wbu_lsu #(.XLEN(32), .TIMEOUT(T32)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_rd(in_rd),
      .in_addr(in_addr[31:0]), .in_wdata(in_wdata[31:0]), .in_alu_res(in_alu_res[31:0]),
      .in_pc(in_pc[31:0]), .in_csr_out(in_csr_out[31:0]),
      .mem_req(a_mem_req), .mem_gnt(mem_gnt & ~sel), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
      .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata[31:0]),
      .rf_wen(a_rf_wen), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
      .wb_valid(a_wb_valid), .wb_pc(a_wb_pc), .err(a_err), .err_cause(a_err_cause)
   );

   wbu_lsu #(.XLEN(64), .TIMEOUT(T64)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & sel), .in_ready(b_in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_rd(in_rd),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_res(in_alu_res),
      .in_pc(in_pc), .in_csr_out(in_csr_out),
      .mem_req(b_mem_req), .mem_gnt(mem_gnt & sel), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
      .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata),
      .rf_wen(b_rf_wen), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
      .wb_valid(b_wb_valid), .wb_pc(b_wb_pc), .err(b_err), .err_cause(b_err_cause)
   );

   logic        o_in_ready, o_mem_req, o_mem_we, o_rf_wen, o_wb_valid, o_err;
   logic [63:0] o_mem_addr, o_mem_wdata, o_rf_wdata, o_wb_pc;
   logic [7:0]  o_mem_wmask;
   logic [4:0]  o_rf_waddr;
   logic [1:0]  o_err_cause;

   always_comb begin
      if (sel) begin
         o_in_ready = b_in_ready;  o_mem_req = b_mem_req;     o_mem_we = b_mem_we;
         o_rf_wen = b_rf_wen;      o_wb_valid = b_wb_valid;   o_err = b_err;
         o_mem_addr = b_mem_addr;  o_mem_wdata = b_mem_wdata; o_rf_wdata = b_rf_wdata;
         o_wb_pc = b_wb_pc;        o_mem_wmask = b_mem_wmask; o_rf_waddr = b_rf_waddr;
         o_err_cause = b_err_cause;
      end else begin
         o_in_ready = a_in_ready;  o_mem_req = a_mem_req;     o_mem_we = a_mem_we;
         o_rf_wen = a_rf_wen;      o_wb_valid = a_wb_valid;   o_err = a_err;
         o_mem_addr = {32'd0, a_mem_addr};   o_mem_wdata = {32'd0, a_mem_wdata};
         o_rf_wdata = {32'd0, a_rf_wdata};   o_wb_pc = {32'd0, a_wb_pc};
         o_mem_wmask = {4'd0, a_mem_wmask};  o_rf_waddr = a_rf_waddr;
         o_err_cause = a_err_cause;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] e_rfw, e_maddr, e_mwdata;
   logic [7:0]  e_wmask;
   logic [1:0]  e_cause;
   logic        e_wen;
   int          e_lat, e_req;

   // gd: REQ cycle (0-based) in which the bench grants; rv: extra WAIT cycles
   // before rvalid. The access owns tmo cycles; grant and response must both
   // fall inside them, otherwise the access aborts once tmo cycles are used.
   task automatic model(input int xlen, input int tmo, input logic [1:0] op,
                        input logic [2:0] f3, input logic [1:0] wsel, input logic [4:0] rd,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] alu, input logic [63:0] pc,
                        input logic [63:0] csr, input logic [63:0] rdata,
                        input int gd, input int rv);
      logic [63:0] xm, v, bm, ld;
      int nb, bytes, ofs;
      bit is_ld, is_st, legal;
      xm    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      nb    = xlen / 8;
      bytes = 1 << f3[1:0];
      ofs   = int'(addr[2:0]) % nb;
      is_ld = (op == 2'b01);
      is_st = (op == 2'b10);
      if (is_ld) legal = (f3 != 3'b111) && !(xlen == 32 && (f3 == 3'b011 || f3 == 3'b110));
      else       legal = (f3[2] == 1'b0) && !(xlen == 32 && f3 == 3'b011);
      ld = 64'd0; e_cause = 2'd0; e_lat = 1; e_req = 0;
      if (is_ld || is_st) begin
         if (!legal) e_cause = 2'd3;
         else if (ofs % bytes != 0) e_cause = 2'd1;
         else if (gd >= tmo || gd + 1 + rv >= tmo) begin
            e_cause = 2'd2;
            e_lat   = tmo + 2;
            e_req   = (gd < tmo) ? gd + 1 : tmo;
         end else begin
            e_lat = gd + rv + 3;
            e_req = gd + 1;
            if (is_ld) begin
               v = (rdata & xm) >> (8 * ofs);
               if (bytes < 8) begin
                  bm = (64'd1 << (8 * bytes)) - 64'd1;
                  v  = v & bm;
                  if (!f3[2] && v[8*bytes-1]) v = v | ~bm;
               end
               ld = v & xm;
            end
         end
      end
      case (wsel)
         2'd0:    e_rfw = alu & xm;
         2'd1:    e_rfw = (pc + 64'd4) & xm;
         2'd2:    e_rfw = csr & xm;
         default: e_rfw = ld;
      endcase
      e_wen    = !is_st && (e_cause == 2'd0) && (rd != 5'd0);
      e_maddr  = addr & ~64'(nb - 1) & xm;
      e_wmask  = 8'(((16'd1 << bytes) - 16'd1) << ofs) & 8'((16'd1 << nb) - 16'd1);
      e_mwdata = (wdata << (8 * ofs)) & xm;
   endtask

   // ---------------- transaction driver ----------------
   logic [63:0] obs_rfw, obs_maddr, obs_mwdata;
   logic [7:0]  obs_wmask;
   logic [1:0]  obs_cause;
   logic        obs_wen;
   int          obs_lat, obs_req;

   task automatic run_txn(input logic s, input logic [1:0] op, input logic [2:0] f3,
                          input logic [1:0] wsel, input logic [4:0] rd,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] alu, input logic [63:0] pc,
                          input logic [63:0] csr, input logic [63:0] rdata,
                          input int gd, input int rv);
      int k;
      bit seen;
      model(s ? 64 : 32, s ? T64 : T32, op, f3, wsel, rd, addr, wdata, alu, pc, csr, rdata, gd, rv);
      @(negedge clk);
      sel = s;
      #1;
      check("idle_ready", 64'(o_in_ready), 64'd1);
      in_valid = 1'b1; in_op = op; in_funct3 = f3; in_wb_sel = wsel; in_rd = rd;
      in_addr = addr; in_wdata = wdata; in_alu_res = alu; in_pc = pc; in_csr_out = csr;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~rdata;
      seen = 1'b0; k = 0; obs_req = 0; obs_lat = -1;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         in_valid = 1'b0;
         in_op = 2'($urandom); in_funct3 = 3'($urandom); in_rd = 5'($urandom);
         in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
         in_alu_res = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
         if (o_mem_req) begin
            if (obs_req == 0) begin
               obs_maddr = o_mem_addr; obs_wmask = o_mem_wmask; obs_mwdata = o_mem_wdata;
               check("mem_we", 64'(o_mem_we), 64'(op == 2'b10));
               check("mem_addr", o_mem_addr, e_maddr);
               if (op == 2'b10) begin
                  check("mem_wmask", 64'(o_mem_wmask), 64'(e_wmask));
                  check("mem_wdata", o_mem_wdata, e_mwdata);
               end
            end
            obs_req++;
         end
         if (o_wb_valid) begin
            seen = 1'b1;
            obs_lat = k; obs_rfw = o_rf_wdata; obs_cause = o_err_cause; obs_wen = o_rf_wen;
            check("wb_latency", 64'(k), 64'(e_lat));
            check("wb_ready", 64'(o_in_ready), 64'd0);
            check("err", 64'(o_err), 64'(e_cause != 2'd0));
            check("err_cause", 64'(o_err_cause), 64'(e_cause));
            check("rf_wen", 64'(o_rf_wen), 64'(e_wen));
            check("wb_pc", o_wb_pc, pc & (s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF));
            if (e_wen) begin
               check("rf_waddr", 64'(o_rf_waddr), 64'(rd));
               check("rf_wdata", o_rf_wdata, e_rfw);
            end
         end
         mem_gnt    = (k - 1 == gd);
         mem_rvalid = (k - 1 == gd + 1 + rv);
         mem_rdata  = mem_rvalid ? rdata : ~rdata;
      end
      if (!seen) check("wb_seen", 64'd0, 64'd1);
      check("req_cycles", 64'(obs_req), 64'(e_req));
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   initial begin
      logic [1:0]  r_op, r_ws;
      logic [2:0]  r_f3;
      logic [63:0] r_addr;
      logic        r_s;
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      in_op = '0; in_funct3 = '0; in_wb_sel = '0; in_rd = '0;
      in_addr = '0; in_wdata = '0; in_alu_res = '0; in_pc = '0; in_csr_out = '0; mem_rdata = '0;

      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = i[0];
         #1;
         check("rst_in_ready", 64'(o_in_ready), 64'd1);
         check("rst_mem_req", 64'(o_mem_req), 64'd0);
         check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
         check("rst_rf_wen", 64'(o_rf_wen), 64'd0);
         check("rst_err", 64'(o_err), 64'd0);
         check("rst_mem_addr", o_mem_addr, 64'd0);
         check("rst_rf_wdata", o_rf_wdata, 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // ALU op, one cycle to commit, no memory traffic
      run_txn(0, 2'b00, 3'b000, 2'b00, 5'd5, 64'h0, 64'h0, 64'h1234, 64'h100, 64'h0, 64'h0, 0, 0);
      check("alu_value", obs_rfw, 64'h1234);
      check("alu_lat", 64'(obs_lat), 64'd1);
      // lb / lbu with immediate grant and rvalid one cycle later
      run_txn(0, 2'b01, 3'b000, 2'b11, 5'd7, 64'h1003, 64'h0, 64'h0, 64'h200, 64'h0, 64'h80FF_FF00, 0, 0);
      check("lb_value", obs_rfw, 64'hFFFF_FF80);
      check("lb_lat", 64'(obs_lat), 64'd3);
      run_txn(0, 2'b01, 3'b100, 2'b11, 5'd7, 64'h1003, 64'h0, 64'h0, 64'h204, 64'h0, 64'h80FF_FF00, 0, 0);
      check("lbu_value", obs_rfw, 64'h80);
      // sh to the upper half-word
      run_txn(0, 2'b10, 3'b001, 2'b00, 5'd9, 64'h1002, 64'hABCD, 64'h55, 64'h208, 64'h0, 64'h0, 0, 1);
      check("sh_wmask", 64'(obs_wmask), 64'hC);
      check("sh_wdata", obs_mwdata, 64'hABCD_0000);
      check("sh_addr", obs_maddr, 64'h1000);
      check("sh_rf_wen", 64'(obs_wen), 64'd0);
      // misaligned lw
      run_txn(0, 2'b01, 3'b010, 2'b11, 5'd3, 64'h1002, 64'h0, 64'h0, 64'h20C, 64'h0, 64'h0, 0, 0);
      check("mis_cause", 64'(obs_cause), 64'd1);
      check("mis_lat", 64'(obs_lat), 64'd1);
      // no grant ever: timeout
      run_txn(0, 2'b01, 3'b010, 2'b11, 5'd3, 64'h1000, 64'h0, 64'h0, 64'h210, 64'h0, 64'h0, 100, 0);
      check("tmo_cause", 64'(obs_cause), 64'd2);
      check("tmo_req", 64'(obs_req), 64'd4);
      // ld on both widths
      run_txn(1, 2'b01, 3'b011, 2'b11, 5'd4, 64'h8, 64'h0, 64'h0, 64'h300, 64'h0, 64'h8000_0000_0000_0001, 0, 0);
      check("ld64_value", obs_rfw, 64'h8000_0000_0000_0001);
      run_txn(0, 2'b01, 3'b011, 2'b11, 5'd4, 64'h8, 64'h0, 64'h0, 64'h304, 64'h0, 64'h0, 0, 0);
      check("ld32_cause", 64'(obs_cause), 64'd3);

      // reset while waiting for the response; the late rvalid must be ignored
      @(negedge clk);
      sel = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_funct3 = 3'b011; in_wb_sel = 2'b11;
      in_rd = 5'd6; in_addr = 64'h10; in_pc = 64'h400;
      @(negedge clk);
      in_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      check("rstw_in_ready", 64'(o_in_ready), 64'd1);
      check("rstw_mem_req", 64'(o_mem_req), 64'd0);
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         check("rstw_no_wb", 64'(o_wb_valid), 64'd0);
         check("rstw_ready", 64'(o_in_ready), 64'd1);
      end

      // randomized traffic on both widths
      for (int n = 0; n < 400; n++) begin
         r_s  = 1'($urandom);
         r_op = ($urandom % 3 == 0) ? 2'($urandom) : (($urandom % 2 == 0) ? 2'b01 : 2'b10);
         r_f3 = 3'($urandom);
         r_ws = (r_op == 2'b01 && $urandom % 4 != 0) ? 2'b11 : 2'($urandom);
         r_addr = {$urandom, $urandom};
         if ($urandom % 4 != 0) r_addr = r_addr & ~(64'(1 << r_f3[1:0]) - 64'd1);
         run_txn(r_s, r_op, r_f3, r_ws, ($urandom % 8 == 0) ? 5'd0 : 5'($urandom), r_addr,
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom % 16 == 0) ? 20 : int'($urandom % 6), int'($urandom % 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wbu_lsu.md
Name: wbu_lsu

Overview:
- Parametrised writeback/load-store stage for the NPC core; sits after EXU and drives the architectural register file.
- Replaces the single-cycle, combinational writeback path with a multi-cycle FSM that talks to a variable-latency memory port (req/gnt, rvalid).
- Adds XLEN=32/64 support, store byte-mask generation, misalignment detection and a response timeout.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TIMEOUT, 255, maximum number of cycles in REQ+WAIT before the access is aborted; must be at least 1.
- NB, XLEN/8, number of byte lanes (derived localparam).
- OFS_W, $clog2(NB), number of address offset bits (derived localparam).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EXU has an instruction for this stage
- in_ready  out  1  stage can accept an instruction
- in_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- in_funct3  in  3  access width and sign (RISC-V encoding)
- in_wb_sel  in  2  00 alu_res, 01 pc+4, 10 csr_out, 11 load data
- in_rd  in  5  destination register
- in_addr  in  XLEN  effective address
- in_wdata  in  XLEN  store data (low bits significant)
- in_alu_res  in  XLEN  ALU result
- in_pc  in  XLEN  instruction PC
- in_csr_out  in  XLEN  CSR read value
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  address, aligned down to NB bytes
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  NB  byte enables
- mem_rvalid  in  1  response/ack for the accepted request
- mem_rdata  in  XLEN  aligned read word
- rf_wen  out  1  register-file write strobe
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- wb_valid  out  1  one-cycle commit pulse
- wb_pc  out  XLEN  PC of the committing instruction
- err  out  1  commit carries an exception
- err_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal width

Behaviour:
- Reset: state=IDLE; in_ready=1; mem_req, rf_wen, wb_valid and err=0; all data outputs and captured registers=0; timeout counter=0.
- IDLE
  - in_ready=1.
  - On in_valid, all inputs are captured.
  - Non-memory op goes to WB.
  - Memory op with a misalignment or illegal width goes to WB with err set.
  - Any other memory op goes to REQ.
- REQ
  - mem_req=1 and mem_addr/we/wdata/wmask are held stable until mem_gnt.
  - On mem_gnt the FSM goes to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT
  - On mem_rvalid, mem_rdata is captured and the FSM goes to WAIT→WB.
  - A store also waits for mem_rvalid, which acts as its ack.
- Timeout
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT, the FSM goes to WB with cause=10, and mem_req drops in that same cycle.
- WB (one cycle, then IDLE)
  - wb_valid=1 and wb_pc is driven.
  - rf_wen=1 only when: op is not a store, there is no error, and rd≠0.
  - in_ready=0.
- in_ready is 1 only in IDLE, so at most one instruction is in flight.
- Latency:
  - Non-memory op: accepted in cycle N, WB in N+1.
  - Load with gnt in N+1 and rvalid in N+2: WB in N+3.
- Width (funct3):
  - 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - 011 ld and 110 lwu are legal only when XLEN=64.
  - 111, and any 64-bit-only code when XLEN=32, give cause 11.
  - Stores use only 000/001/010/011.
- Misalignment: half with ofs[0]≠0; word with ofs[1:0]≠0; double with ofs[2:0]≠0; where ofs=addr[OFS_W-1:0].
- Load extraction: mem_rdata >> (ofs*8), truncated to the access width, then sign- or zero-extended to XLEN.
- Store lanes:
  - wmask = ((1<<bytes)-1) << ofs.
  - wdata = in_wdata << (ofs*8).
- rf_wdata mux: 00 alu_res, 01 pc+4 (XLEN-bit wrap), 10 csr_out, 11 extracted load data.
- Reset asserted mid-access returns the FSM to IDLE immediately. Any in-flight memory response arriving later must be ignored; the memory side is reset by the same rst.

Decomposition:
- Shared package wbu_pkg holds:
  - op encodings, funct3 width constants, the wb_sel encodings and error cause codes;
  - the state enum {IDLE, REQ, WAIT, WB}.
- One combinational sub-module, load_align, performs the ofs shift plus sign/zero extension, parametrised by XLEN.

Test Plan:
- ALU op, wb_sel=00, rd=5, alu_res=0x1234 -> wb_valid and rf_wen one cycle after accept, rf_wdata=0x1234, no mem_req.
- lb, addr=0x1003, rdata=0x80FF_FF00 (gnt immediate, rvalid +1) -> rf_wdata=0xFFFF_FF80, WB 3 cycles after accept; same access with lbu gives 0x0000_0080.
- sh, addr=0x1002, wdata=0xABCD -> mem_wmask=4'b1100, mem_wdata=0xABCD_0000, mem_addr=0x1000, rf_wen=0, WB after rvalid ack.
- lw, addr=0x1002 -> no mem_req, err=1, err_cause=01, rf_wen=0, WB one cycle after accept.
- TIMEOUT=4, mem_gnt never asserted -> mem_req high 4 cycles then low, err_cause=10, in_ready returns next cycle.
- XLEN=64: ld, addr=0x8, rdata=0x8000_0000_0000_0001 -> rf_wdata equals rdata. XLEN=32: ld -> err_cause=11. Also assert rst during WAIT -> in_ready=1 next edge, no wb_valid.
